// File: rtl/ad_packetizer.sv
// ADC capture and Avalon-ST framing stage: packs sample pairs into 32-bit words
// and emits one packet of a programmed word count through a show-ahead FIFO.
module ad_packetizer #(
    parameter int SAMPLE_W   = 14,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          control,
    input  logic [15:0]         length,
    output logic [3:0]          status,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                sync_in,
    output logic [31:0]         dma_data,
    output logic                dma_valid,
    input  logic                dma_ready,
    output logic                dma_sop,
    output logic                dma_eop,
    output logic [1:0]          dma_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

    state_t          state, state_nx;
    logic            start_prev, start_edge, sync_prev, sync_edge;
    logic [15:0]     len, wr_cnt, rd_cnt;
    logic            half, done, overflow;
    logic [15:0]     hold;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            abort, start_ok, empty, full;
    logic            rd_en, word_done, wr_en, last_wr, last_rd;
    logic            unused_ctrl;

    function automatic logic [15:0] sext16(input logic signed [SAMPLE_W-1:0] s);
        return 16'(s);
    endfunction

    assign unused_ctrl = ^control[7:3];
    assign abort       = control[1];
    assign start_ok    = start_edge && (length != 16'd0);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A same-cycle read frees the slot, so a word completing on a full FIFO is kept.
    assign rd_en     = !empty && dma_ready;
    assign word_done = (state == CAPTURE) && adc_valid && half;
    assign wr_en     = word_done && (!full || rd_en);
    assign last_wr   = wr_en && (wr_cnt == len - 16'd1);
    assign last_rd   = rd_en && (rd_cnt == len - 16'd1);

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_nx = control[2] ? ARM : CAPTURE;
                ARM:     if (sync_edge) state_nx = CAPTURE;
                CAPTURE: if (last_wr) state_nx = DRAIN;
                DRAIN:   if (last_rd) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            start_prev <= 1'b0;
            start_edge <= 1'b0;
            sync_prev  <= 1'b0;
            sync_edge  <= 1'b0;
            len        <= 16'd0;
            wr_cnt     <= 16'd0;
            rd_cnt     <= 16'd0;
            half       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nx;
            start_prev <= control[0];
            start_edge <= control[0] && !start_prev;
            sync_prev  <= sync_in;
            sync_edge  <= sync_in && !sync_prev;
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                wr_cnt <= 16'd0;
                rd_cnt <= 16'd0;
                half   <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                    rd_cnt <= rd_cnt + 16'd1;
                end
                if (wr_en) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                    wr_cnt <= wr_cnt + 16'd1;
                end
                if (word_done && !wr_en)
                    overflow <= 1'b1;
                if ((state == CAPTURE) && adc_valid)
                    half <= !half;
                if ((state == DRAIN) && last_rd)
                    done <= 1'b1;
                if ((state == IDLE) && start_ok) begin
                    len      <= length;
                    done     <= 1'b0;
                    overflow <= 1'b0;
                    wr_cnt   <= 16'd0;
                    rd_cnt   <= 16'd0;
                    half     <= 1'b0;
                end
            end
        end
    end

    // Sample and FIFO storage carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if ((state == CAPTURE) && adc_valid && !half)
            hold <= sext16(adc_data);
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {sext16(adc_data), hold};
    end

    assign dma_valid = !empty;
    assign dma_data  = dma_valid ? mem[rd_ptr[AW-1:0]] : 32'd0;
    assign dma_sop   = dma_valid && (rd_cnt == 16'd0);
    assign dma_eop   = dma_valid && (rd_cnt == len - 16'd1);
    assign dma_empty = 2'd0;
    assign status    = {state == ARM, overflow, done, state != IDLE};

endmodule

// File: tb/tb_ad_packetizer.sv
// Randomized bench for ad_packetizer: a packet-level queue model predicts every
// output cycle, plus literal expectations for the documented scenarios.
module tb_ad_packetizer;
    localparam int SAMPLE_W   = 14;
    localparam int FIFO_DEPTH = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          control = 8'd0;
    logic [15:0]         length = 16'd0;
    logic [3:0]          status;
    logic [SAMPLE_W-1:0] adc_data = '0;
    logic                adc_valid = 1'b0;
    logic                sync_in = 1'b0;
    logic [31:0]         dma_data;
    logic                dma_valid;
    logic                dma_ready = 1'b1;
    logic                dma_sop, dma_eop;
    logic [1:0]          dma_empty;

    ad_packetizer #(.SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .control(control), .length(length), .status(status),
        .adc_data(adc_data), .adc_valid(adc_valid), .sync_in(sync_in),
        .dma_data(dma_data), .dma_valid(dma_valid), .dma_ready(dma_ready),
        .dma_sop(dma_sop), .dma_eop(dma_eop), .dma_empty(dma_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sx(input logic [SAMPLE_W-1:0] v);
        int s;
        s = int'(v);
        if (v[SAMPLE_W-1]) s = s - (1 << SAMPLE_W);
        return 16'(s);
    endfunction

    // Packet-level model: expected words sit in a queue until the sink takes them.
    typedef enum {M_IDLE, M_ARM, M_CAP, M_DRAIN} mph_t;
    mph_t        ph = M_IDLE;
    logic [31:0] q[$];
    int          mlen = 0, wr = 0, rd = 0;
    bit          done_m = 0, ovf_m = 0, have_first = 0;
    logic [15:0] first = 16'd0;
    bit          c0_d1 = 0, c0_d2 = 0, s_d1 = 0, s_d2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = M_IDLE; q.delete(); mlen = 0; wr = 0; rd = 0;
            done_m = 0; ovf_m = 0; have_first = 0;
            c0_d1 = 0; c0_d2 = 0; s_d1 = 0; s_d2 = 0;
        end else begin
            bit   xfer;
            mph_t old;
            old  = ph;
            xfer = (q.size() > 0) && dma_ready;
            if (control[1]) begin
                ph = M_IDLE; q.delete(); wr = 0; rd = 0; have_first = 0;
            end else begin
                if (xfer) begin
                    void'(q.pop_front());
                    rd++;
                end
                case (old)
                    M_IDLE: if (c0_d1 && !c0_d2 && length != 16'd0) begin
                        mlen = int'(length); done_m = 0; ovf_m = 0;
                        wr = 0; rd = 0; have_first = 0;
                        ph = control[2] ? M_ARM : M_CAP;
                    end
                    M_ARM: if (s_d1 && !s_d2) ph = M_CAP;
                    M_CAP: if (adc_valid) begin
                        if (!have_first) begin
                            first = sx(adc_data);
                            have_first = 1;
                        end else begin
                            have_first = 0;
                            if (q.size() < FIFO_DEPTH) begin
                                q.push_back({sx(adc_data), first});
                                wr++;
                                if (wr == mlen) ph = M_DRAIN;
                            end else begin
                                ovf_m = 1;
                            end
                        end
                    end
                    M_DRAIN: if (xfer && rd == mlen) begin
                        ph = M_IDLE;
                        done_m = 1;
                    end
                    default: ;
                endcase
            end
            c0_d2 = c0_d1; c0_d1 = control[0];
            s_d2 = s_d1; s_d1 = sync_in;
        end
    end

    // Per-cycle comparison against the model; accepted words are logged.
    bit          chk_en = 0;
    logic [31:0] log_w[$];
    logic [1:0]  log_se[$];

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("valid", 32'(dma_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("data", dma_data, q[0]);
                chk("sop", 32'(dma_sop), 32'(rd == 0));
                chk("eop", 32'(dma_eop), 32'(rd == mlen - 1));
            end else begin
                chk("data_idle", dma_data, 32'd0);
                chk("sop_idle", 32'(dma_sop), 32'd0);
                chk("eop_idle", 32'(dma_eop), 32'd0);
            end
            chk("status", 32'(status),
                32'({ph == M_ARM, ovf_m, done_m, ph != M_IDLE}));
            chk("empty", 32'(dma_empty), 32'd0);
            if (dma_valid && dma_ready) begin
                log_w.push_back(dma_data);
                log_se.push_back({dma_sop, dma_eop});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns once the state has left IDLE; the next driven sample is sample 0.
    task automatic start_pkt(input int len, input bit sync_en);
        length  = 16'(len);
        control = {5'd0, sync_en, 1'b0, 1'b1};
        cyc(1);
        control[0] = 1'b0;
        cyc(1);
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = SAMPLE_W'($urandom);
            cyc(1);
        end
        adc_valid = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int budget, input bit stream);
        int n;
        n = 0;
        while ((status[0] || dma_valid) && n < budget) begin
            if (stream) begin
                adc_valid = ($urandom_range(0, 9) < 7);
                adc_data  = SAMPLE_W'($urandom);
                dma_ready = ($urandom_range(0, 3) != 0);
            end
            cyc(1);
            n++;
        end
        adc_valid = 1'b0;
        dma_ready = 1'b1;
        cyc(1);
        chk(name, 32'({status[0], dma_valid}), 32'd0);
    endtask

    logic [SAMPLE_W-1:0] smp[16];
    int                  neop;
    int                  plen;
    bit                  psync;

    initial begin
        cyc(3);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_valid", 32'(dma_valid), 32'd0);
        chk("rst_sopeop", 32'({dma_sop, dma_eop}), 32'd0);
        chk("rst_data", dma_data, 32'd0);
        rst = 1'b0;
        chk_en = 1;
        cyc(2);

        // Basic 4-word packet with ramp samples
        log_w.delete(); log_se.delete();
        start_pkt(4, 1'b0);
        for (int i = 0; i < 8; i++) begin
            adc_valid = 1'b1;
            adc_data  = SAMPLE_W'(i);
            cyc(1);
        end
        adc_valid = 1'b0;
        run_until_idle("basic_idle", 50, 1'b0);
        chk("basic_count", 32'(log_w.size()), 32'd4);
        if (log_w.size() == 4) begin
            chk("basic_w0", log_w[0], 32'h0001_0000);
            chk("basic_w1", log_w[1], 32'h0003_0002);
            chk("basic_w2", log_w[2], 32'h0005_0004);
            chk("basic_w3", log_w[3], 32'h0007_0006);
            chk("basic_se0", 32'(log_se[0]), 32'd2);
            chk("basic_se3", 32'(log_se[3]), 32'd1);
        end
        chk("basic_status", 32'(status), 32'b0010);

        // Sign extension
        log_w.delete(); log_se.delete();
        start_pkt(1, 1'b0);
        adc_valid = 1'b1; adc_data = SAMPLE_W'(14'h3FFF); cyc(1);
        adc_data = SAMPLE_W'(14'h2000); cyc(1);
        adc_valid = 1'b0;
        run_until_idle("sext_idle", 50, 1'b0);
        chk("sext_count", 32'(log_w.size()), 32'd1);
        if (log_w.size() > 0) chk("sext_word", log_w[0], 32'hE000_FFFF);

        // Sync-triggered capture
        log_w.delete(); log_se.delete();
        start_pkt(2, 1'b1);
        feed(6);
        chk("armed_status", 32'(status), 32'b1001);
        chk("armed_novalid", 32'(dma_valid), 32'd0);
        for (int i = 0; i < 12; i++) begin
            smp[i]    = SAMPLE_W'($urandom);
            adc_valid = 1'b1;
            adc_data  = smp[i];
            if (i == 0) sync_in = 1'b1;
            cyc(1);
        end
        adc_valid = 1'b0;
        sync_in   = 1'b0;
        run_until_idle("sync_idle", 50, 1'b0);
        chk("sync_count", 32'(log_w.size()), 32'd2);
        if (log_w.size() == 2) begin
            chk("sync_w0", log_w[0], {sx(smp[3]), sx(smp[2])});
            chk("sync_w1", log_w[1], {sx(smp[5]), sx(smp[4])});
        end

        // Overflow with the sink stalled
        dma_ready = 1'b0;
        start_pkt(64, 1'b0);
        feed(40);
        cyc(2);
        chk("ovf_status", 32'(status), 32'b0101);
        chk("ovf_valid", 32'(dma_valid), 32'd1);
        log_w.delete(); log_se.delete();
        dma_ready = 1'b1;
        cyc(24);
        chk("ovf_drained", 32'(log_w.size()), 32'd16);
        neop = 0;
        foreach (log_se[i]) if (log_se[i][0]) neop++;
        chk("ovf_no_eop", 32'(neop), 32'd0);
        chk("ovf_not_done", 32'(status), 32'b0101);
        control[1] = 1'b1; cyc(1);
        control = 8'd0; cyc(1);
        chk("ovf_abort_status", 32'(status), 32'b0100);

        // Abort mid-packet, then a single-word packet
        log_w.delete(); log_se.delete();
        start_pkt(10, 1'b0);
        for (int n = 0; n < 100 && log_w.size() < 3; n++) begin
            adc_valid = 1'b1;
            adc_data  = SAMPLE_W'($urandom);
            cyc(1);
        end
        control[1] = 1'b1;
        cyc(1);
        chk("abort_valid", 32'(dma_valid), 32'd0);
        chk("abort_status", 32'(status), 32'd0);
        control = 8'd0; adc_valid = 1'b0;
        cyc(2);
        log_w.delete(); log_se.delete();
        start_pkt(1, 1'b0);
        feed(2);
        run_until_idle("single_idle", 50, 1'b0);
        chk("single_count", 32'(log_w.size()), 32'd1);
        if (log_w.size() > 0) chk("single_sopeop", 32'(log_se[0]), 32'd3);

        // Asynchronous reset during DRAIN
        dma_ready = 1'b0;
        start_pkt(8, 1'b0);
        feed(16);
        cyc(1);
        chk("drain_status", 32'(status), 32'b0001);
        chk("drain_valid", 32'(dma_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_status", 32'(status), 32'd0);
        chk("arst_valid", 32'(dma_valid), 32'd0);
        chk("arst_sopeop", 32'({dma_sop, dma_eop}), 32'd0);
        chk("arst_data", dma_data, 32'd0);
        cyc(2);
        rst = 1'b0;
        dma_ready = 1'b1;
        cyc(1);
        log_w.delete(); log_se.delete();
        start_pkt(3, 1'b0);
        feed(6);
        run_until_idle("post_rst_idle", 50, 1'b0);
        chk("post_rst_count", 32'(log_w.size()), 32'd3);
        chk("post_rst_status", 32'(status), 32'b0010);

        // Randomized packets with random valid/ready and optional sync
        for (int p = 0; p < 8; p++) begin
            plen  = $urandom_range(1, 20);
            psync = 1'($urandom_range(0, 1));
            log_w.delete(); log_se.delete();
            start_pkt(plen, psync);
            if (psync) begin
                repeat ($urandom_range(0, 4)) begin
                    adc_valid = 1'($urandom_range(0, 1));
                    adc_data  = SAMPLE_W'($urandom);
                    cyc(1);
                end
                sync_in = 1'b1; cyc(1);
                sync_in = 1'b0;
            end
            run_until_idle("rand_idle", 2000, 1'b1);
            if (!ovf_m) chk("rand_count", 32'(log_w.size()), 32'(plen));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
